// File: rtl/mcu_share_pkg.sv
// Shared definitions for the MCU arbiter: FSM states, ERR bit positions,
// the DRAM_SEL code used during refresh, and a one-hot helper.
package mcu_share_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_OWN_A,
    S_OWN_B,
    S_REFRESH,
    S_TURN
  } state_t;

  localparam logic [1:0] ERR_ILLEGAL  = 2'd0;
  localparam logic [1:0] ERR_RFRS_OVF = 2'd1;
  localparam logic [1:0] ERR_WDOG     = 2'd2;

  localparam logic [1:0] SEL_REFRESH = 2'b11;

  function automatic logic onehot2(input logic [1:0] v);
    return v[0] ^ v[1];
  endfunction

endpackage

// File: rtl/toggle_sync_ctr.sv
// Refresh bookkeeping: edge detector on a toggle-coded strobe feeding a
// saturating 2-bit pending counter with a decrement port.
module toggle_sync_ctr #(
  parameter logic [1:0] MAX = 2'h3
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       strobe_i,
  input  logic       dec_i,
  output logic [1:0] count_o,
  output logic       ovf_o
);

  logic       strobe_q;
  logic [1:0] count_q;
  logic [1:0] count_d;
  logic       edge_s;

  // A new request and a completion in the same cycle cancel out.
  always_comb begin
    edge_s  = strobe_i ^ strobe_q;
    count_d = count_q;
    ovf_o   = 1'b0;
    if (edge_s && !dec_i) begin
      if (count_q == MAX) ovf_o = 1'b1;
      else                count_d = count_q + 2'd1;
    end else if (!edge_s && dec_i && count_q != '0) begin
      count_d = count_q - 2'd1;
    end
  end

  // The strobe copy is loaded during reset as well so release never sees an edge.
  always_ff @(posedge clk_i) begin
    strobe_q <= strobe_i;
    if (!rst_ni) count_q <= '0;
    else         count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/mcu_share.sv
// Arbiter sharing one DRAM controller between the Gremlin aligner (A), the CPU
// port (B) and refresh. Define MCU_SHARE_WATCHDOG_EN for the hold watchdog.
module mcu_share #(
  parameter logic [11:0] HOLD_LIMIT = 12'hfff,
  parameter logic [1:0]  RFRS_MAX   = 2'h3
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [1:0] REQ_ALIGN_A,
  output logic [1:0] GRANT_ALIGN_A,
  input  logic       REQ_B,
  input  logic [1:0] SEL_B,
  output logic       GRANT_B,
  input  logic       REFRESH_STROBE,
  output logic [1:0] DRAM_SEL,
  output logic       DRAM_REFRESH,
  input  logic       DRAM_REFRESH_DONE,
  output logic [2:0] ERR
);
  import mcu_share_pkg::*;

  state_t     state_q;
  logic [1:0] grant_a_q;
  logic       grant_b_q;
  logic [1:0] dram_sel_q;
  logic       dram_refresh_q;
  logic       prefer_b_q;
  logic [2:0] err_q;

  logic [1:0] pending;
  logic       ovf;
  logic       dec;
  logic       wdog_fire;
  logic       lock_a;
  logic       lock_b;
  logic       a_bad, b_bad, a_legal, b_legal, a_go, b_go;

  toggle_sync_ctr #(.MAX(RFRS_MAX)) u_rfrs (
    .clk_i    (CLK),
    .rst_ni   (RST),
    .strobe_i (REFRESH_STROBE),
    .dec_i    (dec),
    .count_o  (pending),
    .ovf_o    (ovf)
  );

`ifdef MCU_SHARE_WATCHDOG_EN
  logic [11:0] hold_q;
  logic        lock_a_q;
  logic        lock_b_q;

  assign wdog_fire = (hold_q == HOLD_LIMIT - 12'd1);
  assign lock_a    = lock_a_q;
  assign lock_b    = lock_b_q;

  // A released requester stays locked out until it has dropped its request once.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      hold_q   <= '0;
      lock_a_q <= 1'b0;
      lock_b_q <= 1'b0;
    end else begin
      if (state_q == S_IDLE || state_q == S_TURN) hold_q <= '0;
      else                                        hold_q <= hold_q + 12'd1;
      if (state_q == S_OWN_A && REQ_ALIGN_A != '0 && wdog_fire) lock_a_q <= 1'b1;
      else if (REQ_ALIGN_A == '0)                                lock_a_q <= 1'b0;
      if (state_q == S_OWN_B && REQ_B && wdog_fire) lock_b_q <= 1'b1;
      else if (!REQ_B)                              lock_b_q <= 1'b0;
    end
  end
`else
  logic [11:0] unused_hold_limit;
  assign unused_hold_limit = HOLD_LIMIT;
  assign wdog_fire = 1'b0;
  assign lock_a    = 1'b0;
  assign lock_b    = 1'b0;
`endif

  always_comb begin
    a_bad   = (REQ_ALIGN_A == 2'b11);
    b_bad   = REQ_B && !onehot2(SEL_B);
    a_legal = onehot2(REQ_ALIGN_A) && !lock_a;
    b_legal = REQ_B && onehot2(SEL_B) && !lock_b;
    a_go    = a_legal && !(b_legal && prefer_b_q);
    b_go    = b_legal && !a_go;
    dec     = (state_q == S_REFRESH) && (DRAM_REFRESH_DONE || wdog_fire);
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q        <= S_IDLE;
      grant_a_q      <= '0;
      grant_b_q      <= 1'b0;
      dram_sel_q     <= '0;
      dram_refresh_q <= 1'b0;
      prefer_b_q     <= 1'b0;
      err_q          <= '0;
    end else begin
      dram_refresh_q <= 1'b0;
      if (ovf) err_q[ERR_RFRS_OVF] <= 1'b1;
      unique case (state_q)
        S_IDLE: begin
          if (a_bad || b_bad) err_q[ERR_ILLEGAL] <= 1'b1;
          if (pending != '0) begin
            state_q        <= S_REFRESH;
            dram_sel_q     <= SEL_REFRESH;
            dram_refresh_q <= 1'b1;
          end else if (a_go) begin
            state_q    <= S_OWN_A;
            grant_a_q  <= REQ_ALIGN_A;
            dram_sel_q <= REQ_ALIGN_A;
            prefer_b_q <= 1'b1;
          end else if (b_go) begin
            state_q    <= S_OWN_B;
            grant_b_q  <= 1'b1;
            dram_sel_q <= SEL_B;
            prefer_b_q <= 1'b0;
          end
        end
        S_OWN_A: begin
          if (REQ_ALIGN_A == '0 || wdog_fire) begin
            state_q    <= S_TURN;
            grant_a_q  <= '0;
            dram_sel_q <= '0;
            if (REQ_ALIGN_A != '0) err_q[ERR_WDOG] <= 1'b1;
          end
        end
        S_OWN_B: begin
          if (!REQ_B || wdog_fire) begin
            state_q    <= S_TURN;
            grant_b_q  <= 1'b0;
            dram_sel_q <= '0;
            if (REQ_B) err_q[ERR_WDOG] <= 1'b1;
          end
        end
        S_REFRESH: begin
          if (DRAM_REFRESH_DONE || wdog_fire) begin
            state_q    <= S_TURN;
            dram_sel_q <= '0;
            if (!DRAM_REFRESH_DONE) err_q[ERR_WDOG] <= 1'b1;
          end
        end
        S_TURN:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign GRANT_ALIGN_A = grant_a_q;
  assign GRANT_B       = grant_b_q;
  assign DRAM_SEL      = dram_sel_q;
  assign DRAM_REFRESH  = dram_refresh_q;
  assign ERR           = err_q;

endmodule

// File: tb/tb_mcu_share.sv
// Bench for mcu_share: directed vector table, hand-written multi-cycle sequences and a
// randomized run against a transaction-level model. Watchdog checks follow MCU_SHARE_WATCHDOG_EN.
module tb_mcu_share;

  localparam logic [11:0] HL = 12'd16;

  logic       CLK = 1'b0;
  logic       RST;
  logic [1:0] REQ_ALIGN_A;
  logic       REQ_B;
  logic [1:0] SEL_B;
  logic       REFRESH_STROBE;
  logic       DRAM_REFRESH_DONE;
  logic [1:0] GRANT_ALIGN_A;
  logic       GRANT_B;
  logic [1:0] DRAM_SEL;
  logic       DRAM_REFRESH;
  logic [2:0] ERR;

  int n_vec = 0;
  int n_bad = 0;

  mcu_share #(.HOLD_LIMIT(HL), .RFRS_MAX(2'h3)) dut (
    .CLK               (CLK),
    .RST               (RST),
    .REQ_ALIGN_A       (REQ_ALIGN_A),
    .GRANT_ALIGN_A     (GRANT_ALIGN_A),
    .REQ_B             (REQ_B),
    .SEL_B             (SEL_B),
    .GRANT_B           (GRANT_B),
    .REFRESH_STROBE    (REFRESH_STROBE),
    .DRAM_SEL          (DRAM_SEL),
    .DRAM_REFRESH      (DRAM_REFRESH),
    .DRAM_REFRESH_DONE (DRAM_REFRESH_DONE),
    .ERR               (ERR)
  );

  always #5 CLK = ~CLK;

  // Reference model: who holds the controller, plus a one-cycle gap after every release.
  int         m_owner;   // 0 nobody, 1 A, 2 B, 3 refresh
  bit         m_gap;
  int         m_pend;
  bit         m_prev_st;
  bit         m_last_a;  // A was the most recent winner
  logic [2:0] m_err;
  bit         m_lock_a, m_lock_b;
  int         m_hold;
  logic [1:0] e_ga, e_sel;
  logic       e_gb, e_ref;

  function automatic logic [8:0] pk(logic [1:0] ga, logic gb, logic [1:0] sel, logic rf, logic [2:0] er);
    return {ga, gb, sel, rf, er};
  endfunction

  function automatic logic [8:0] model_exp();
    return pk(e_ga, e_gb, e_sel, e_ref, m_err);
  endfunction

  task automatic release_owner();
    m_owner = 0; m_gap = 1; e_ga = 2'b00; e_gb = 1'b0; e_sel = 2'b00;
  endtask

  task automatic model_step();
    bit edge_s, done_one, wd, a_one, b_one, a_ok, b_ok;
    if (!RST) begin
      m_owner = 0; m_gap = 0; m_pend = 0; m_last_a = 0; m_err = 3'b000;
      m_lock_a = 0; m_lock_b = 0; m_hold = 0; m_prev_st = REFRESH_STROBE;
      e_ga = 2'b00; e_gb = 1'b0; e_sel = 2'b00; e_ref = 1'b0;
      return;
    end
    edge_s = (REFRESH_STROBE != m_prev_st);
    m_prev_st = REFRESH_STROBE;
    done_one = 0;
    e_ref = 1'b0;
`ifdef MCU_SHARE_WATCHDOG_EN
    wd = (m_hold == int'(HL) - 1);
`else
    wd = 0;
`endif
    a_one = (REQ_ALIGN_A == 2'b01 || REQ_ALIGN_A == 2'b10);
    b_one = (SEL_B == 2'b01 || SEL_B == 2'b10);
    if (REQ_ALIGN_A == 2'b00) m_lock_a = 0;
    if (!REQ_B) m_lock_b = 0;
    if (m_gap) begin
      m_gap = 0;
    end else begin
      case (m_owner)
        0: begin
          if (REQ_ALIGN_A == 2'b11 || (REQ_B && !b_one)) m_err[0] = 1'b1;
          a_ok = a_one && !m_lock_a;
          b_ok = REQ_B && b_one && !m_lock_b;
          m_hold = 0;
          if (m_pend > 0) begin
            m_owner = 3; e_sel = 2'b11; e_ref = 1'b1;
          end else if (a_ok && (!b_ok || !m_last_a)) begin
            m_owner = 1; e_ga = REQ_ALIGN_A; e_sel = REQ_ALIGN_A; m_last_a = 1;
          end else if (b_ok) begin
            m_owner = 2; e_gb = 1'b1; e_sel = SEL_B; m_last_a = 0;
          end
        end
        1: begin
          if (REQ_ALIGN_A == 2'b00) release_owner();
          else if (wd) begin release_owner(); m_err[2] = 1'b1; m_lock_a = 1; end
          else m_hold++;
        end
        2: begin
          if (!REQ_B) release_owner();
          else if (wd) begin release_owner(); m_err[2] = 1'b1; m_lock_b = 1; end
          else m_hold++;
        end
        default: begin
          if (DRAM_REFRESH_DONE) begin release_owner(); done_one = 1; end
          else if (wd) begin release_owner(); done_one = 1; m_err[2] = 1'b1; end
          else m_hold++;
        end
      endcase
    end
    if (edge_s && !done_one) begin
      if (m_pend == 3) m_err[1] = 1'b1;
      else             m_pend++;
    end else if (done_one && !edge_s && m_pend > 0) begin
      m_pend--;
    end
  endtask

  // Inputs are changed at the falling edge; the model consumes them ahead of the rising edge.
  task automatic tick();
    model_step();
    @(negedge CLK);
  endtask

  task automatic check(input string name, input logic [8:0] exp);
    logic [8:0] act;
    act = {GRANT_ALIGN_A, GRANT_B, DRAM_SEL, DRAM_REFRESH, ERR};
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got ga=%b gb=%b sel=%b ref=%b err=%b, want ga=%b gb=%b sel=%b ref=%b err=%b",
               name, act[8:7], act[6], act[5:4], act[3], act[2:0],
               exp[8:7], exp[6], exp[5:4], exp[3], exp[2:0]);
    end
  endtask

  task automatic rst_seq();
    RST = 1'b0; REQ_ALIGN_A = 2'b00; REQ_B = 1'b0; SEL_B = 2'b00; DRAM_REFRESH_DONE = 1'b0;
    tick(); tick();
    RST = 1'b1;
  endtask

  typedef struct {
    logic [1:0] ra; logic rb; logic [1:0] sb;
    logic [1:0] ga; logic gb; logic [1:0] sel; logic [2:0] er;
  } vec_t;

  vec_t tbl[19];
  int   pulses;
  int unsigned r;

  initial begin
    tbl[0]  = '{2'b01, 1'b1, 2'b10, 2'b01, 1'b0, 2'b01, 3'b000};
    tbl[1]  = '{2'b01, 1'b1, 2'b10, 2'b01, 1'b0, 2'b01, 3'b000};
    tbl[2]  = '{2'b10, 1'b1, 2'b10, 2'b01, 1'b0, 2'b01, 3'b000};
    tbl[3]  = '{2'b00, 1'b1, 2'b10, 2'b00, 1'b0, 2'b00, 3'b000};
    tbl[4]  = '{2'b00, 1'b1, 2'b10, 2'b00, 1'b0, 2'b00, 3'b000};
    tbl[5]  = '{2'b00, 1'b1, 2'b10, 2'b00, 1'b1, 2'b10, 3'b000};
    tbl[6]  = '{2'b01, 1'b1, 2'b01, 2'b00, 1'b1, 2'b10, 3'b000};
    tbl[7]  = '{2'b01, 1'b0, 2'b01, 2'b00, 1'b0, 2'b00, 3'b000};
    tbl[8]  = '{2'b01, 1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 3'b000};
    tbl[9]  = '{2'b01, 1'b0, 2'b00, 2'b01, 1'b0, 2'b01, 3'b000};
    tbl[10] = '{2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 3'b000};
    tbl[11] = '{2'b11, 1'b1, 2'b10, 2'b00, 1'b0, 2'b00, 3'b000};
    tbl[12] = '{2'b11, 1'b1, 2'b10, 2'b00, 1'b1, 2'b10, 3'b001};
    tbl[13] = '{2'b00, 1'b0, 2'b10, 2'b00, 1'b0, 2'b00, 3'b001};
    tbl[14] = '{2'b01, 1'b1, 2'b11, 2'b00, 1'b0, 2'b00, 3'b001};
    tbl[15] = '{2'b01, 1'b1, 2'b11, 2'b01, 1'b0, 2'b01, 3'b001};
    tbl[16] = '{2'b00, 1'b1, 2'b00, 2'b00, 1'b0, 2'b00, 3'b001};
    tbl[17] = '{2'b00, 1'b1, 2'b00, 2'b00, 1'b0, 2'b00, 3'b001};
    tbl[18] = '{2'b00, 1'b1, 2'b00, 2'b00, 1'b0, 2'b00, 3'b001};

    // Reset with the strobe high: no refresh may appear after release.
    RST = 1'b0; REQ_ALIGN_A = 2'b00; REQ_B = 1'b0; SEL_B = 2'b00;
    REFRESH_STROBE = 1'b1; DRAM_REFRESH_DONE = 1'b0;
    @(negedge CLK);
    rst_seq();
    check("reset", pk(2'b00, 1'b0, 2'b00, 1'b0, 3'b000));
    for (int i = 0; i < 3; i++) begin
      tick();
      check("no_spurious_refresh", pk(2'b00, 1'b0, 2'b00, 1'b0, 3'b000));
    end

    for (int i = 0; i < 19; i++) begin
      REQ_ALIGN_A = tbl[i].ra; REQ_B = tbl[i].rb; SEL_B = tbl[i].sb;
      tick();
      check($sformatf("table[%0d]", i), pk(tbl[i].ga, tbl[i].gb, tbl[i].sel, 1'b0, tbl[i].er));
    end

    // Grant one cycle after request, one TURN cycle after drop, then IDLE.
    rst_seq();
    tick();
    REQ_ALIGN_A = 2'b01;
    tick();
    check("latency_grant", pk(2'b01, 1'b0, 2'b01, 1'b0, 3'b000));
    for (int i = 0; i < 14; i++) begin
      if (i == 7) REQ_ALIGN_A = 2'b10;
      tick();
      check("hold_a", pk(2'b01, 1'b0, 2'b01, 1'b0, 3'b000));
    end
    REQ_ALIGN_A = 2'b00;
    tick();
    check("turn", pk(2'b00, 1'b0, 2'b00, 1'b0, 3'b000));
    REQ_B = 1'b1; SEL_B = 2'b01;
    tick();
    check("idle_after_turn", pk(2'b00, 1'b0, 2'b00, 1'b0, 3'b000));
    tick();
    check("b_after_idle", pk(2'b00, 1'b1, 2'b01, 1'b0, 3'b000));

    // Round-robin alternation with both requesters active.
    rst_seq();
    REQ_ALIGN_A = 2'b01; REQ_B = 1'b1; SEL_B = 2'b10;
    tick();
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) check("rr_a", pk(2'b01, 1'b0, 2'b01, 1'b0, 3'b000));
      else            check("rr_b", pk(2'b00, 1'b1, 2'b10, 1'b0, 3'b000));
      if (i % 2 == 0) REQ_ALIGN_A = 2'b00; else REQ_B = 1'b0;
      tick();
      check("rr_turn", pk(2'b00, 1'b0, 2'b00, 1'b0, 3'b000));
      REQ_ALIGN_A = 2'b01; REQ_B = 1'b1;
      tick();
      check("rr_idle", pk(2'b00, 1'b0, 2'b00, 1'b0, 3'b000));
      tick();
    end

    // Refresh waits for the owner to finish, then runs until DONE.
    rst_seq();
    REQ_B = 1'b1; SEL_B = 2'b10;
    tick();
    REFRESH_STROBE = ~REFRESH_STROBE;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("no_preempt", pk(2'b00, 1'b1, 2'b10, 1'b0, 3'b000));
    end
    REQ_B = 1'b0;
    tick();
    check("rf_turn", pk(2'b00, 1'b0, 2'b00, 1'b0, 3'b000));
    tick();
    check("rf_idle", pk(2'b00, 1'b0, 2'b00, 1'b0, 3'b000));
    tick();
    check("rf_start", pk(2'b00, 1'b0, 2'b11, 1'b1, 3'b000));
    for (int i = 0; i < 6; i++) begin
      if (i == 5) DRAM_REFRESH_DONE = 1'b1;
      tick();
      check("rf_busy", i == 5 ? pk(2'b00, 1'b0, 2'b00, 1'b0, 3'b000)
                              : pk(2'b00, 1'b0, 2'b11, 1'b0, 3'b000));
    end
    DRAM_REFRESH_DONE = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("rf_drained", pk(2'b00, 1'b0, 2'b00, 1'b0, 3'b000));
    end

    // Saturation at three pending, then an edge coinciding with DONE.
    rst_seq();
    REQ_ALIGN_A = 2'b01;
    tick();
    for (int i = 0; i < 4; i++) begin
      REFRESH_STROBE = ~REFRESH_STROBE;
      tick();
      check("sat_edge", pk(2'b01, 1'b0, 2'b01, 1'b0, i == 3 ? 3'b010 : 3'b000));
    end
    REQ_ALIGN_A = 2'b00;
    tick(); tick(); tick();
    check("sat_refresh_start", pk(2'b00, 1'b0, 2'b11, 1'b1, 3'b010));
    DRAM_REFRESH_DONE = 1'b1;
    REFRESH_STROBE = ~REFRESH_STROBE;
    tick();
    check("sat_coincident", pk(2'b00, 1'b0, 2'b00, 1'b0, 3'b010));
    pulses = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (DRAM_REFRESH) pulses++;
    end
    n_vec++;
    if (pulses != 3) begin
      n_bad++;
      $display("FAIL sat_pending: got %0d refresh pulses, want 3", pulses);
    end
    DRAM_REFRESH_DONE = 1'b0;
    check("sat_err_sticky", pk(2'b00, 1'b0, 2'b00, 1'b0, 3'b010));

    // Long hold by A: watchdog release and lockout when enabled, plain hold otherwise.
    rst_seq();
    REQ_ALIGN_A = 2'b01;
    for (int i = 0; i < 40; i++) begin
      tick();
`ifdef MCU_SHARE_WATCHDOG_EN
      check("wdog_hold", i < int'(HL) ? pk(2'b01, 1'b0, 2'b01, 1'b0, 3'b000)
                                      : pk(2'b00, 1'b0, 2'b00, 1'b0, 3'b100));
`else
      check("long_hold", pk(2'b01, 1'b0, 2'b01, 1'b0, 3'b000));
`endif
    end
    REQ_ALIGN_A = 2'b00;
    tick();
`ifdef MCU_SHARE_WATCHDOG_EN
    REQ_ALIGN_A = 2'b01;
    tick();
    check("wdog_regrant", pk(2'b01, 1'b0, 2'b01, 1'b0, 3'b100));
`else
    REQ_ALIGN_A = 2'b01;
    tick(); tick();
    check("long_regrant", pk(2'b01, 1'b0, 2'b01, 1'b0, 3'b000));
`endif
    REQ_ALIGN_A = 2'b00;
    tick(); tick();

    // Randomized run against the model.
    rst_seq();
    for (int i = 0; i < 3000; i++) begin
      RST = ($urandom_range(0, 399) != 0);
      if ($urandom_range(0, 7) == 0) begin
        r = $urandom_range(0, 15);
        REQ_ALIGN_A = (r < 6) ? 2'b00 : (r < 11) ? 2'b01 : (r < 15) ? 2'b10 : 2'b11;
      end
      if ($urandom_range(0, 7) == 0) REQ_B = ~REQ_B;
      if ($urandom_range(0, 7) == 0) begin
        r = $urandom_range(0, 15);
        SEL_B = (r < 7) ? 2'b01 : (r < 14) ? 2'b10 : (r == 14) ? 2'b00 : 2'b11;
      end
      if ($urandom_range(0, 11) == 0) REFRESH_STROBE = ~REFRESH_STROBE;
      DRAM_REFRESH_DONE = ($urandom_range(0, 3) == 0);
      tick();
      check("random", model_exp());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
